etc_multilane_gate: RTL and testbench



---
 rtl/etc_pkg.sv | 34 +++
 rtl/etc_lane_fsm.sv | 147 ++++++++++++++
 rtl/etc_multilane_gate.sv | 51 +++++
 tb/tb_etc_multilane_gate.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/etc_pkg.sv
// Shared definitions for the multi-lane ETC gate: lane states, E-pass codes,
// and the timer sizing helper used by every lane.
package etc_pkg;

  // Per-lane sequence state
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    OPEN    = 3'd2,
    PASSING = 3'd3,
    HOLD    = 3'd4,
    DENY    = 3'd5
  } lane_state_t;

  // E-pass reader codes, one 2-bit code per lane
  localparam logic [1:0] EPASS_NONE    = 2'b00;
  localparam logic [1:0] EPASS_VALID   = 2'b01;
  localparam logic [1:0] EPASS_LOWBAL  = 2'b10;
  localparam logic [1:0] EPASS_INVALID = 2'b11;

  // Width of the pass counter per lane
  localparam int PASS_COUNT_W = 16;

  // Largest count any lane timer must represent
  function automatic int timer_max(input int timeout_cycles, input int hold_cycles);
    return (timeout_cycles > hold_cycles) ? timeout_cycles : hold_cycles;
  endfunction

  // Timer width large enough to hold timer_max without wrapping
  function automatic int timer_width(input int timeout_cycles, input int hold_cycles);
    return $clog2(timer_max(timeout_cycles, hold_cycles) + 1);
  endfunction

endpackage

// File: rtl/etc_lane_fsm.sv
// One toll lane: sensor-sequence FSM, E-pass decision, shared wait/hold
// timer, decoded barrier/alarm, and (with ETC_PASS_COUNT_EN defined) a
// saturating count of completed passages.
module etc_lane_fsm
  import etc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int HOLD_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor1,
  input  logic       sensor2,
  input  logic       sensor3,
  input  logic [1:0] valid_epass,
  output logic       barrier_q,
  output logic       alarm
`ifdef ETC_PASS_COUNT_EN
  ,
  output logic [PASS_COUNT_W-1:0] pass_count
`endif
);

  localparam int TIMER_W   = timer_width(TIMEOUT_CYCLES, HOLD_CYCLES);
  localparam int TIMER_TOP = timer_max(TIMEOUT_CYCLES, HOLD_CYCLES);

  // Timer value seen during the last cycle of a wait/hold window
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_SAT    = TIMER_W'(TIMER_TOP);

  lane_state_t          state_reg;
  lane_state_t          state_next;
  logic [TIMER_W-1:0]   timer_reg;
  logic [TIMER_W-1:0]   timer_next;
  logic                 code_valid;
  logic                 code_reject;

  assign code_valid  = (valid_epass == EPASS_VALID);
  assign code_reject = (valid_epass == EPASS_LOWBAL) || (valid_epass == EPASS_INVALID);

  // State and timer registers; reset drops the lane straight back to IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  // Next-state decision for the lane sequence
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (sensor1) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        // valid code beats a reject code, which beats the vehicle leaving,
        // which beats the no-tag timeout
        if (code_valid) begin
          state_next = OPEN;
        end else if (code_reject) begin
          state_next = DENY;
        end else if (!sensor1) begin
          state_next = IDLE;
        end else if (timer_reg >= TIMEOUT_LAST) begin
          state_next = DENY;
        end
      end
      OPEN: begin
        // sensor3 alone means nothing here; only the barrier-line sensor advances
        if (sensor2) begin
          state_next = PASSING;
        end else if (timer_reg >= TIMEOUT_LAST) begin
          state_next = HOLD;
        end
      end
      PASSING: begin
        // deliberately no timeout: a vehicle may be under the barrier
        if (sensor3) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (timer_reg >= HOLD_LAST) begin
          state_next = sensor1 ? CHECK : IDLE;
        end
      end
      DENY: begin
        if (!sensor1 && !sensor2) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Timer restarts on every state change and otherwise counts up to saturation
  always_comb begin
    timer_next = timer_reg;
    if (state_next != state_reg) begin
      timer_next = '0;
    end else if (timer_reg < TIMER_SAT) begin
      timer_next = timer_reg + TIMER_W'(1);
    end
  end

  // Moore outputs decoded from the registered state only
  always_comb begin
    barrier_q = 1'b0;
    alarm     = 1'b0;
    case (state_reg)
      OPEN, PASSING, HOLD: barrier_q = 1'b1;
      DENY:                alarm     = 1'b1;
      default: begin
        barrier_q = 1'b0;
        alarm     = 1'b0;
      end
    endcase
  end

`ifdef ETC_PASS_COUNT_EN
  logic [PASS_COUNT_W-1:0] count_reg;
  logic                    pass_done;

  assign pass_done = (state_reg == PASSING) && (state_next == HOLD);

  // Count completed passages, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (pass_done && (count_reg != {PASS_COUNT_W{1'b1}})) begin
      count_reg <= count_reg + PASS_COUNT_W'(1);
    end
  end

  assign pass_count = count_reg;
`endif

endmodule

// File: rtl/etc_multilane_gate.sv
// Multi-lane ETC gate: NUM_LANES independent lane FSMs with a per-lane
// manual override that forces the barrier open without touching the FSM.
// Optional feature macro: ETC_PASS_COUNT_EN adds the pass_count output.
module etc_multilane_gate
  import etc_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int HOLD_CYCLES    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_LANES-1:0]   sensor1,
  input  logic [NUM_LANES-1:0]   sensor2,
  input  logic [NUM_LANES-1:0]   sensor3,
  input  logic [2*NUM_LANES-1:0] valid_epass,
  input  logic [NUM_LANES-1:0]   enable,
  output logic [NUM_LANES-1:0]   barrier,
  output logic [NUM_LANES-1:0]   alarm
`ifdef ETC_PASS_COUNT_EN
  ,
  output logic [PASS_COUNT_W*NUM_LANES-1:0] pass_count
`endif
);

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic barrier_q;

    etc_lane_fsm #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_lane (
      .clk         (clk),
      .reset_n     (reset_n),
      .sensor1     (sensor1[gi]),
      .sensor2     (sensor2[gi]),
      .sensor3     (sensor3[gi]),
      .valid_epass (valid_epass[2*gi +: 2]),
      .barrier_q   (barrier_q),
      .alarm       (alarm[gi])
`ifdef ETC_PASS_COUNT_EN
      ,
      .pass_count  (pass_count[PASS_COUNT_W*gi +: PASS_COUNT_W])
`endif
    );

    // Override is purely combinational so it works even while in reset
    assign barrier[gi] = enable[gi] | barrier_q;
  end

endmodule

// File: tb/tb_etc_multilane_gate.sv
// Testbench for etc_multilane_gate: directed lane scenarios followed by
// randomized traffic, all checked every cycle against a lane-behaviour model.
module tb_etc_multilane_gate;

  localparam int NL = 4;
  localparam int TO = 64;
  localparam int HC = 16;

  // model phases of a lane
  localparam int P_IDLE = 0, P_CHECK = 1, P_OPEN = 2, P_PASS = 3, P_HOLD = 4, P_DENY = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NL-1:0]     sensor1, sensor2, sensor3, enable;
  logic [2*NL-1:0]   valid_epass;
  logic [NL-1:0]     barrier, alarm;
`ifdef ETC_PASS_COUNT_EN
  logic [16*NL-1:0]  pass_count;
`endif

  int checks = 0;
  int errors = 0;

  int phase[NL];
  int dwell[NL];
  int passes[NL];

  always #5 clk = ~clk;

  etc_multilane_gate #(
    .NUM_LANES      (NL),
    .TIMEOUT_CYCLES (TO),
    .HOLD_CYCLES    (HC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sensor1     (sensor1),
    .sensor2     (sensor2),
    .sensor3     (sensor3),
    .valid_epass (valid_epass),
    .enable      (enable),
    .barrier     (barrier),
    .alarm       (alarm)
`ifdef ETC_PASS_COUNT_EN
    ,
    .pass_count  (pass_count)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      phase[i]  = P_IDLE;
      dwell[i]  = 0;
      passes[i] = 0;
    end
  endtask

  // one clock edge of lane behaviour; dwell = edges already spent in the phase
  task automatic model_step();
    for (int i = 0; i < NL; i++) begin
      int nxt;
      bit s1, s2, s3;
      logic [1:0] code;
      s1   = sensor1[i];
      s2   = sensor2[i];
      s3   = sensor3[i];
      code = valid_epass[2*i +: 2];
      nxt  = phase[i];
      case (phase[i])
        P_IDLE:  if (s1) nxt = P_CHECK;
        P_CHECK: begin
          if (code == 2'b01)               nxt = P_OPEN;
          else if (code != 2'b00)          nxt = P_DENY;
          else if (!s1)                    nxt = P_IDLE;
          else if (dwell[i] + 1 >= TO)     nxt = P_DENY;
        end
        P_OPEN: begin
          if (s2)                          nxt = P_PASS;
          else if (dwell[i] + 1 >= TO)     nxt = P_HOLD;
        end
        P_PASS: begin
          if (s3) begin
            nxt = P_HOLD;
            if (passes[i] < 65535) passes[i]++;
          end
        end
        P_HOLD:  if (dwell[i] + 1 >= HC) nxt = s1 ? P_CHECK : P_IDLE;
        default: if (!s1 && !s2) nxt = P_IDLE;
      endcase
      if (nxt != phase[i]) dwell[i] = 0;
      else                 dwell[i]++;
      phase[i] = nxt;
    end
  endtask

  task automatic compare(input string tag);
    logic [NL-1:0] exp_bar, exp_alm;
    exp_bar = enable;
    exp_alm = '0;
    for (int i = 0; i < NL; i++) begin
      if (phase[i] == P_OPEN || phase[i] == P_PASS || phase[i] == P_HOLD) exp_bar[i] = 1'b1;
      if (phase[i] == P_DENY) exp_alm[i] = 1'b1;
    end
    check_val({tag, "_barrier"}, 64'(barrier), 64'(exp_bar));
    check_val({tag, "_alarm"}, 64'(alarm), 64'(exp_alm));
`ifdef ETC_PASS_COUNT_EN
    for (int i = 0; i < NL; i++) begin
      check_val({tag, "_pass_count"}, 64'(pass_count[16*i +: 16]), 64'(passes[i]));
    end
`endif
  endtask

  // advance n cycles, model follows each edge, compare on the falling edge
  task automatic tick(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (reset_n) model_step();
      else         model_reset();
      @(negedge clk);
      compare(tag);
    end
  endtask

  task automatic set_lane(input int i, input bit s1, input bit s2, input bit s3, input logic [1:0] code);
    sensor1[i] = s1;
    sensor2[i] = s2;
    sensor3[i] = s3;
    valid_epass[2*i +: 2] = code;
  endtask

  task automatic clear_inputs();
    sensor1 = '0;
    sensor2 = '0;
    sensor3 = '0;
    valid_epass = '0;
    enable = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    compare("reset");
    check_val("reset_barrier_low", 64'(barrier), 64'd0);
    reset_n = 1'b1;
    tick(2, "idle");

    // lane 0: valid pass with full hold window
    set_lane(0, 1, 0, 0, 2'b00);
    tick(3, "l0_check");
    set_lane(0, 1, 0, 0, 2'b01);
    tick(1, "l0_valid");
    check_val("l0_open", 64'(barrier[0]), 64'd1);
    set_lane(0, 0, 1, 0, 2'b00);
    tick(2, "l0_pass");
    set_lane(0, 0, 0, 1, 2'b00);
    tick(1, "l0_exit");
    set_lane(0, 0, 0, 0, 2'b00);
    tick(HC - 1, "l0_hold");
    check_val("l0_hold_end_open", 64'(barrier[0]), 64'd1);
    tick(1, "l0_close");
    check_val("l0_closed", 64'(barrier[0]), 64'd0);

    // lane 1: blacklisted tag -> alarm, clears when lane empties
    set_lane(1, 1, 0, 0, 2'b00);
    tick(1, "l1_check");
    set_lane(1, 1, 0, 0, 2'b11);
    tick(1, "l1_deny");
    check_val("l1_alarm", 64'(alarm), 64'b0010);
    check_val("l1_barrier", 64'(barrier), 64'd0);
    set_lane(1, 0, 0, 0, 2'b00);
    tick(1, "l1_clear");
    check_val("l1_alarm_clear", 64'(alarm[1]), 64'd0);

    // lane 2: no-tag timeout, then OPEN timeout into HOLD
    set_lane(2, 1, 0, 0, 2'b00);
    tick(1, "l2_check");
    tick(TO - 1, "l2_wait");
    check_val("l2_no_alarm_yet", 64'(alarm[2]), 64'd0);
    tick(1, "l2_timeout");
    check_val("l2_deny", 64'(alarm[2]), 64'd1);
    set_lane(2, 0, 0, 0, 2'b00);
    tick(1, "l2_idle");
    set_lane(2, 1, 0, 0, 2'b00);
    tick(1, "l2_check2");
    set_lane(2, 0, 0, 0, 2'b01);
    tick(1, "l2_open");
    set_lane(2, 0, 0, 0, 2'b00);
    tick(TO, "l2_open_wait");
    tick(HC - 1, "l2_hold");
    check_val("l2_hold_open", 64'(barrier[2]), 64'd1);
    tick(1, "l2_close");
    check_val("l2_closed", 64'(barrier[2]), 64'd0);

    // lane 3: override in IDLE and in DENY
    enable[3] = 1'b1;
    #1;
    check_val("l3_ovr_idle", 64'(barrier[3]), 64'd1);
    set_lane(3, 1, 0, 0, 2'b00);
    tick(1, "l3_check");
    set_lane(3, 1, 0, 0, 2'b10);
    tick(1, "l3_deny");
    check_val("l3_ovr_alarm", 64'(alarm[3]), 64'd1);
    check_val("l3_ovr_deny", 64'(barrier[3]), 64'd1);
    enable[3] = 1'b0;
    #1;
    check_val("l3_release", 64'(barrier[3]), 64'd0);
    set_lane(3, 0, 0, 0, 2'b00);
    tick(1, "l3_idle");

    // asynchronous reset while lane 0 is passing
    set_lane(0, 1, 0, 0, 2'b00);
    tick(1, "rs_check");
    set_lane(0, 1, 0, 0, 2'b01);
    tick(1, "rs_open");
    set_lane(0, 0, 1, 0, 2'b00);
    tick(1, "rs_passing");
    set_lane(0, 0, 0, 0, 2'b00);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_val("rs_async_barrier", 64'(barrier[0]), 64'd0);
    compare("rs_async");
    tick(2, "rs_held");
    reset_n = 1'b1;
    set_lane(0, 1, 0, 0, 2'b00);
    tick(1, "rs_again_check");
    set_lane(0, 1, 0, 0, 2'b01);
    tick(1, "rs_again_open");
    check_val("rs_again_barrier", 64'(barrier[0]), 64'd1);

    // next vehicle arriving during HOLD gets its own check
    set_lane(0, 0, 1, 0, 2'b00);
    tick(1, "rh_pass");
    set_lane(0, 0, 0, 1, 2'b00);
    tick(1, "rh_hold");
    set_lane(0, 1, 0, 0, 2'b00);
    tick(HC, "rh_expire");
    check_val("rh_check_closed", 64'(barrier[0]), 64'd0);
    set_lane(0, 1, 0, 0, 2'b01);
    tick(1, "rh_reopen");
    check_val("rh_reopened", 64'(barrier[0]), 64'd1);
    set_lane(0, 0, 1, 1, 2'b00);
    tick(2, "rh_both");
    clear_inputs();
    tick(HC + 4, "settle");

    // randomized traffic on all lanes
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NL; i++) begin
        int r;
        logic [1:0] code;
        r = int'($urandom_range(0, 15));
        code = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
        set_lane(i, ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), code);
        enable[i] = ($urandom_range(0, 15) == 0);
      end
      #1;
      compare("rand_comb");
      tick(1, "rand");
    end

    clear_inputs();
    tick(TO + HC + 2, "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
